// File: rtl/ahb_rr_burst_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahb_rr_burst_arbiter_if
// Bus bundle between the requesting masters / slave stall and the
// round-robin burst arbiter.
//   hreq    : one request bit per master (bit i = master i)
//   hburst  : per-master AHB HBURST code, hburst[i] belongs to master i
//   hwait   : slave stall, a beat completes only when hsel=1 and hwait=0
//   hgrant  : one-hot grant, all-zero when the bus is unowned
//   hsel    : OR of hgrant
//   hmaster : index of the granted master, 0 when unowned
//   hlast   : high in the cycle the final beat of a tenure completes
// Modports: slave  = arbiter side (consumes requests, produces grants)
//           master = requester/environment side
// ----------------------------------------------------------------------------
interface ahb_rr_burst_arbiter_if #(
    parameter int MASTER_NUM = 3
);
    localparam int IDX_W = $clog2(MASTER_NUM);

    logic [MASTER_NUM-1:0]       hreq;
    logic [MASTER_NUM-1:0][2:0]  hburst;
    logic                        hwait;
    logic [MASTER_NUM-1:0]       hgrant;
    logic                        hsel;
    logic [IDX_W-1:0]            hmaster;
    logic                        hlast;

    modport slave (
        input  hreq, hburst, hwait,
        output hgrant, hsel, hmaster, hlast
    );

    modport master (
        output hreq, hburst, hwait,
        input  hgrant, hsel, hmaster, hlast
    );
endinterface

// File: rtl/ahb_rr_burst_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_rr_burst_arbiter
// Round-robin AHB bus arbiter that keeps the grant for a whole burst tenure.
// Fixed-length bursts run to their beat count; undefined-length INCR bursts
// run until the owner drops its request or INCR_MAX_BEATS beats complete.
// At tenure end the next owner is chosen in the same cycle, so back-to-back
// tenures have no idle gap.
// Ports:
//   hclk     : clock, rising edge
//   hreset_n : asynchronous active-low reset
//   bus      : ahb_rr_burst_arbiter_if.slave (hreq/hburst/hwait in,
//              hgrant/hsel/hmaster/hlast out)
// ----------------------------------------------------------------------------
module ahb_rr_burst_arbiter #(
    parameter int MASTER_NUM     = 3,
    parameter int INCR_MAX_BEATS = 16
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    ahb_rr_burst_arbiter_if.slave     bus
);
    localparam int         IDX_W   = $clog2(MASTER_NUM);
    localparam logic [2:0] HB_INCR = 3'd1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_p0, state_p1;
    logic [IDX_W-1:0]       owner_p0, owner_p1;
    logic [IDX_W-1:0]       last_owner_p0, last_owner_p1;
    logic [2:0]             burst_p0, burst_p1;
    logic [4:0]             count_p0, count_p1;
    logic [MASTER_NUM-1:0]  grant_p0, grant_p1;

    logic                   beat_done;
    logic                   tenure_end;
    logic [5:0]             cnt_inc;
    logic [IDX_W-1:0]       arb_ptr;
    logic [IDX_W:0]         pick;
    logic                   pick_vld;
    logic [IDX_W-1:0]       pick_idx;

    // Beat limit of a fixed-length burst (INCR is handled separately).
    function automatic logic [5:0] fixed_limit(input logic [2:0] hb);
        case (hb)
            3'd2, 3'd3: fixed_limit = 6'd4;
            3'd4, 3'd5: fixed_limit = 6'd8;
            3'd6, 3'd7: fixed_limit = 6'd16;
            default:    fixed_limit = 6'd1;
        endcase
    endfunction

    // Round-robin search starting at ptr+1; returns {found, index}.
    // Scanning from the farthest offset down lets the nearest requester win.
    function automatic logic [IDX_W:0] rr_pick(input logic [MASTER_NUM-1:0] req,
                                               input logic [IDX_W-1:0]      ptr);
        logic [IDX_W:0] res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = MASTER_NUM; i >= 1; i--) begin
            idx = IDX_W'((int'(ptr) + i) % MASTER_NUM);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Stage p1: registered arbiter state
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_p1      <= IDLE;
            owner_p1      <= '0;
            last_owner_p1 <= IDX_W'(MASTER_NUM - 1);
            burst_p1      <= '0;
            count_p1      <= '0;
            grant_p1      <= '0;
        end else begin
            state_p1      <= state_p0;
            owner_p1      <= owner_p0;
            last_owner_p1 <= last_owner_p0;
            burst_p1      <= burst_p0;
            count_p1      <= count_p0;
            grant_p1      <= grant_p0;
        end
    end

    // Stage p0: next-state decision
    always_comb begin
        beat_done = (state_p1 == BUSY) && !bus.hwait;
        cnt_inc   = {1'b0, count_p1} + 6'd1;
        if (burst_p1 == HB_INCR)
            tenure_end = beat_done &&
                         (!bus.hreq[owner_p1] || (cnt_inc == 6'(INCR_MAX_BEATS)));
        else
            tenure_end = beat_done && (cnt_inc == fixed_limit(burst_p1));

        // At tenure end the pointer is the owner that just finished.
        arb_ptr  = (state_p1 == BUSY) ? owner_p1 : last_owner_p1;
        pick     = rr_pick(bus.hreq, arb_ptr);
        pick_vld = pick[IDX_W];
        pick_idx = pick[IDX_W-1:0];

        state_p0      = state_p1;
        owner_p0      = owner_p1;
        last_owner_p0 = last_owner_p1;
        burst_p0      = burst_p1;
        count_p0      = count_p1;
        grant_p0      = grant_p1;

        case (state_p1)
            IDLE: begin
                if (pick_vld) begin
                    state_p0 = BUSY;
                    owner_p0 = pick_idx;
                    grant_p0 = MASTER_NUM'(1) << pick_idx;
                    burst_p0 = bus.hburst[pick_idx];
                    count_p0 = '0;
                end
            end
            BUSY: begin
                if (tenure_end) begin
                    last_owner_p0 = owner_p1;
                    count_p0      = '0;
                    if (pick_vld) begin
                        owner_p0 = pick_idx;
                        grant_p0 = MASTER_NUM'(1) << pick_idx;
                        burst_p0 = bus.hburst[pick_idx];
                    end else begin
                        state_p0 = IDLE;
                        owner_p0 = '0;
                        grant_p0 = '0;
                    end
                end else if (beat_done && (count_p1 != 5'd31)) begin
                    count_p0 = cnt_inc[4:0];
                end
            end
            default: state_p0 = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.hgrant  = grant_p1;
        bus.hsel    = |grant_p1;
        bus.hmaster = (state_p1 == BUSY) ? owner_p1 : '0;
        bus.hlast   = tenure_end;
    end
endmodule

// File: doc/ahb_rr_burst_arbiter.md
AHB_RR_BURST_ARBITER -- requirements
Module: ahb_rr_burst_arbiter

Interface
REQ-001 Parameter MASTER_NUM, default 3, SHALL set the number of requesting masters (range 2..8).
REQ-002 Parameter INCR_MAX_BEATS, default 16, SHALL set the maximum beats granted to one undefined-length INCR tenure (range 1..32).
REQ-003 hclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 hreset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 hreq  input  MASTER_NUM  SHALL carry one bus request per master, bit i = master i.
REQ-006 hburst  input  MASTER_NUM x 3  SHALL carry each master's AHB HBURST code (0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16).
REQ-007 hwait  input  1  SHALL indicate a slave stall when high; a beat completes only in a cycle with hsel=1 and hwait=0.
REQ-008 hgrant  output  MASTER_NUM  SHALL be the registered one-hot grant, all-zero when the bus is unowned.
REQ-009 hsel  output  1  SHALL equal the OR of hgrant.
REQ-010 hmaster  output  $clog2(MASTER_NUM)  SHALL give the index of the granted master, 0 when unowned.
REQ-011 hlast  output  1  SHALL pulse high in the cycle the final beat of a tenure completes.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (no owner) and BUSY (owner fixed).
REQ-013 Arbitration SHALL be round-robin: search starts at index last_owner+1 modulo MASTER_NUM; first asserted hreq wins.
REQ-014 In IDLE with any hreq set in cycle t, hgrant SHALL become the winner's one-hot in cycle t+1, and the state SHALL become BUSY.
REQ-015 At grant, the winner's hburst SHALL be latched; beat limit = 1 for SINGLE, 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16.
REQ-016 A 5-bit beat counter SHALL clear at grant and increment by 1 on each completed beat; it SHALL never wrap.
REQ-017 Fixed-length tenure SHALL end on the completed beat where count+1 equals the beat limit, regardless of the owner's hreq.
REQ-018 INCR tenure SHALL end on the first completed beat with the owner's hreq low, or on the completed beat where count+1 equals INCR_MAX_BEATS, whichever comes first.
REQ-019 In a cycle with hwait=1, counter, state, grant and hlast SHALL hold (hlast=0).
REQ-020 At tenure end, hlast SHALL be 1 in that cycle, last_owner SHALL load the current owner, and arbitration SHALL run in the same cycle over hreq with the new pointer.
REQ-021 If any request is pending at tenure end, the new grant SHALL appear in the next cycle with no IDLE gap (back-to-back), counter cleared, burst relatched.
REQ-022 If no request is pending at tenure end, hgrant SHALL go all-zero next cycle and the state SHALL return to IDLE.
REQ-023 The owner SHALL be re-granted at tenure end only if it is the sole requester.
REQ-024 Changes to hreq of non-owners during BUSY SHALL NOT affect the current tenure.
REQ-025 hgrant SHALL never have more than one bit set.

Reset
REQ-026 On hreset_n low, asynchronously: state=IDLE, hgrant=0, hsel=0, hmaster=0, hlast=0, counter=0, last_owner=MASTER_NUM-1 (master 0 highest priority first).
REQ-027 Reset asserted mid-tenure SHALL abort the tenure with no hlast pulse; the first arbitration after release SHALL follow REQ-026 priorities.

Verification
REQ-028 After reset, hreq=3'b111, all hburst=SINGLE, hwait=0 -> grants 001,010,100,001 in consecutive cycles, hlast=1 every cycle.
REQ-029 Master 1 alone, hburst=INCR4, hwait high on beat 2 for 3 cycles -> hgrant=010 held 7 cycles, hlast only on 4th completed beat, then hgrant=0.
REQ-030 Master 0 INCR, hreq held high, hwait=0, INCR_MAX_BEATS=16 -> release after 16 beats with hlast; master 2 requesting gets grant next cycle.
REQ-031 Master 2 WRAP8 drops hreq after beat 3 -> tenure continues to beat 8; hlast only at beat 8.
REQ-032 Reset pulsed during beat 5 of INCR16 -> all outputs 0 immediately; after release, hreq=3'b110 -> hgrant=010.
